// File: rtl/div_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl_pkg
// Purpose  : Shared state encoding and constants for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

package div_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DIV_ITER = `DATA_BUS_WIDTH;

    // Most negative signed operand; paired with -1 it overflows signed DIV.
    localparam logic [DIV_ITER-1:0] SIGNED_OVF = {1'b1, {(DIV_ITER-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/div_seq_ctrl_step.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl_step
// Purpose  : One combinational radix-2 non-restoring iteration on {P,Q}.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq_ctrl_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH:0]   d,
    output logic [WIDTH:0]   p_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] w_p_sh;
    logic [WIDTH:0] w_sum;

    // Sign of the old remainder selects subtract (non-negative) or add back.
    assign w_p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
    assign w_sum  = p[WIDTH] ? (w_p_sh + d) : (w_p_sh - d);

    assign p_next = w_sum;
    assign q_next = {q[WIDTH-2:0], ~w_sum[WIDTH]};

endmodule

`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_ctrl
// Purpose  : Multi-cycle non-restoring divider controller with RISC-V
//            special-case and sign handling. Optional result cache: DIV_CACHE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_ITER,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_d;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_spec_q;
    logic [WIDTH-1:0] w_spec_r;
    logic             w_hit;
    logic [WIDTH:0]   w_p_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_q_out;
    logic [WIDTH-1:0] w_r_out;

    assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
    // Negating the minimum value wraps back to itself, i.e. unsigned 2^(W-1).
    assign w_dvd_abs  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_abs  = w_dvs_neg ? -divisor  : divisor;

    assign w_div_zero = (divisor == '0);
    assign w_ovf      = is_signed && (dividend == c_MIN_NEG) && (divisor == '1);
    assign w_special  = w_div_zero | w_ovf;
    assign w_spec_q   = w_div_zero ? '1 : c_MIN_NEG;
    assign w_spec_r   = w_div_zero ? dividend : '0;

`ifdef DIV_CACHE_EN
    logic             r_c_valid;
    logic             r_c_signed;
    logic [WIDTH-1:0] r_c_dvd;
    logic [WIDTH-1:0] r_c_dvs;
    logic             r_op_signed;
    logic [WIDTH-1:0] r_op_dvd;
    logic [WIDTH-1:0] r_op_dvs;

    // Outputs still hold the cached request's results while valid is set.
    assign w_hit = r_c_valid && (r_c_signed == is_signed) &&
                   (r_c_dvd == dividend) && (r_c_dvs == divisor);
`else
    assign w_hit = 1'b0;
`endif

    div_seq_ctrl_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p      (r_p),
        .q      (r_q),
        .d      (r_d),
        .p_next (w_p_next),
        .q_next (w_q_next)
    );

    assign w_rem_mag = r_p[WIDTH] ? (r_p[WIDTH-1:0] + r_d[WIDTH-1:0]) : r_p[WIDTH-1:0];
    assign w_q_out   = r_neg_q ? -r_q : r_q;
    assign w_r_out   = r_neg_r ? -w_rem_mag : w_rem_mag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            r_cnt     <= '0;
            r_p       <= '0;
            r_q       <= '0;
            r_d       <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`ifdef DIV_CACHE_EN
            r_c_valid   <= 1'b0;
            r_c_signed  <= 1'b0;
            r_c_dvd     <= '0;
            r_c_dvs     <= '0;
            r_op_signed <= 1'b0;
            r_op_dvd    <= '0;
            r_op_dvs    <= '0;
`endif
        end else if (flush) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef DIV_CACHE_EN
            r_c_valid <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (w_hit) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else if (w_special) begin
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            quotient  <= w_spec_q;
                            remainder <= w_spec_r;
`ifdef DIV_CACHE_EN
                            r_c_valid  <= 1'b1;
                            r_c_signed <= is_signed;
                            r_c_dvd    <= dividend;
                            r_c_dvs    <= divisor;
`endif
                        end else begin
                            r_state <= S_CALC;
                            busy    <= 1'b1;
                            r_cnt   <= '0;
                            r_p     <= '0;
                            r_q     <= w_dvd_abs;
                            r_d     <= {1'b0, w_dvs_abs};
                            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r <= w_dvd_neg;
`ifdef DIV_CACHE_EN
                            r_op_signed <= is_signed;
                            r_op_dvd    <= dividend;
                            r_op_dvs    <= divisor;
`endif
                        end
                    end
                end
                S_CALC: begin
                    r_p   <= w_p_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient  <= w_q_out;
                    remainder <= w_r_out;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_DONE;
`ifdef DIV_CACHE_EN
                    r_c_valid  <= 1'b1;
                    r_c_signed <= r_op_signed;
                    r_c_dvd    <= r_op_dvd;
                    r_c_dvs    <= r_op_dvs;
`endif
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
